// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: pre/post-trigger capture sequencer feeding a circular frame buffer.
// Define SCOPE_AUTO_TRIG_EN to add an auto-trigger after TIMEOUT samples in ARM.
module scope_capture_ctrl #(
    parameter int DEPTH     = 1024,
    parameter int AW        = 10,
    parameter int PRE_DEPTH = 256,
    parameter int DIV       = 10,
    parameter int TIMEOUT   = 4096
) (
    input  logic          clk_100m,
    input  logic          s,
    input  logic          run,
    input  logic [7:0]    ad_data,
    input  logic [7:0]    trig_level,
    input  logic          trig_edge,
    input  logic          frame_ack,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] trig_addr,
    output logic          frame_ready,
    output logic [2:0]    state
);

    // state | meaning
    // IDLE  | capture disabled, no writes
    // PRE   | filling the pre-trigger history
    // ARM   | writing samples while watching for the trigger edge
    // POST  | writing the remainder of the frame after the trigger
    // DONE  | frame complete, waiting for frame_ack

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_ARM  = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int DW = $clog2(DIV);

    if (DIV < 2 || PRE_DEPTH < 1 || PRE_DEPTH > DEPTH - 2 || DEPTH != (1 << AW) || TIMEOUT < 1)
    begin : g_bad_params
        $error("scope_capture_ctrl: invalid parameter set");
    end

    state_t        st;
    logic [DW-1:0] div_cnt;
    logic [7:0]    cur;
    logic [7:0]    prev;
    logic          pend;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] pre_cnt;
    logic [AW-1:0] post_left;

    logic tick;
    logic capturing;
    logic adv;
    logic pre_last;
    logic edge_hit;
    logic to_hit;
    logic trig_fire;

    assign tick      = (div_cnt == DW'(DIV - 1));
    assign capturing = (st == ST_PRE) || (st == ST_ARM) || (st == ST_POST);
    // A write scheduled by the previous tick advances the frame only while run holds.
    assign adv       = pend && run;
    assign pre_last  = (pre_cnt == AW'(PRE_DEPTH - 1));
    assign trig_fire = (st == ST_ARM) && adv && (edge_hit || to_hit);
    assign state     = st;

    always_comb begin
        edge_hit = 1'b0;
        if (trig_edge)
            edge_hit = (prev > trig_level) && (cur <= trig_level);
        else
            edge_hit = (prev < trig_level) && (cur >= trig_level);
    end

`ifdef SCOPE_AUTO_TRIG_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_left;

    assign to_hit = (to_left == '0);

    always_ff @(posedge clk_100m or negedge s) begin
        if (!s)
            to_left <= '0;
        else if ((st == ST_PRE) && adv && pre_last)
            to_left <= TW'(TIMEOUT - 1);
        else if ((st == ST_ARM) && adv && !to_hit)
            to_left <= to_left - 1'b1;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk_100m or negedge s) begin
        if (!s) begin
            st          <= ST_IDLE;
            div_cnt     <= '0;
            cur         <= '0;
            prev        <= '0;
            pend        <= 1'b0;
            wr_ptr      <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            trig_addr   <= '0;
            frame_ready <= 1'b0;
            pre_cnt     <= '0;
            post_left   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                cur  <= ad_data;
                prev <= cur;
            end

            // Sample captured on the tick edge is written on the following edge.
            pend  <= tick && run && capturing;
            wr_en <= pend;
            if (pend) begin
                wr_data <= cur;
                wr_addr <= wr_ptr;
                wr_ptr  <= wr_ptr + 1'b1;
            end

            case (st)
                ST_IDLE: begin
                    if (run) begin
                        st      <= ST_PRE;
                        pre_cnt <= '0;
                    end
                end
                ST_PRE: begin
                    if (!run)
                        st <= ST_IDLE;
                    else if (pend) begin
                        if (pre_last)
                            st <= ST_ARM;
                        else
                            pre_cnt <= pre_cnt + 1'b1;
                    end
                end
                ST_ARM: begin
                    if (!run)
                        st <= ST_IDLE;
                    else if (trig_fire) begin
                        trig_addr <= wr_ptr;
                        post_left <= AW'(DEPTH - PRE_DEPTH - 1);
                        st        <= ST_POST;
                    end
                end
                ST_POST: begin
                    if (!run)
                        st <= ST_IDLE;
                    else if (pend) begin
                        if (post_left == AW'(1)) begin
                            st          <= ST_DONE;
                            frame_ready <= 1'b1;
                        end else begin
                            post_left <= post_left - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (frame_ack) begin
                        st          <= ST_PRE;
                        frame_ready <= 1'b0;
                        pre_cnt     <= '0;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule
